// File: rtl/remap_cache_fill_ctrl_pkg.sv
// Shared sizing and types for the RemapCache fill controller: local address,
// config-id and line geometry, plus a helper that bounds config ids.
package remap_cache_fill_ctrl_pkg;

    localparam int LOCAL_ADDR_BW0 = 6;
    localparam int N_ICFG         = 3;
    localparam int VSIZE          = 4;
    localparam int DATA_BW        = 8;

    localparam int LBW     = LOCAL_ADDR_BW0;
    localparam int HBW     = LBW - $clog2(VSIZE);
    localparam int ICFG_BW = $clog2(N_ICFG + 1);
    localparam int DBW     = DATA_BW;

    typedef logic [HBW-1:0]            hiaddr_t;
    typedef logic [HBW:0]              occ_t;
    typedef logic [ICFG_BW-1:0]        icfg_id_t;
    typedef logic [VSIZE-1:0][DBW-1:0] line_t;

    function automatic logic id_valid(input icfg_id_t id);
        return int'(id) < N_ICFG;
    endfunction

endpackage

// File: rtl/remap_cache_fill_ctrl_if.sv
// Handshake bundle between the fill controller and its neighbours: allocation,
// reserved-line request, DRAM return, RemapCache write and free event.
interface remap_cache_fill_ctrl_if;
    import remap_cache_fill_ctrl_pkg::*;

    logic     alloc_rdy;
    logic     alloc_ack;
    icfg_id_t i_alloc_id;
    logic     req_rdy;
    logic     req_ack;
    icfg_id_t o_req_id;
    hiaddr_t  o_req_hiaddr;
    logic     dram_dval;
    icfg_id_t i_dram_id;
    line_t    i_dram_data;
    logic     wad_dval;
    icfg_id_t o_wid;
    hiaddr_t  o_whiaddr;
    line_t    o_wdata;
    logic     free_dval;
    icfg_id_t i_free_id;

    modport slave (
        input  alloc_rdy, i_alloc_id, req_ack, dram_dval, i_dram_id, i_dram_data,
               free_dval, i_free_id,
        output alloc_ack, req_rdy, o_req_id, o_req_hiaddr, wad_dval, o_wid,
               o_whiaddr, o_wdata
    );

    modport master (
        output alloc_rdy, i_alloc_id, req_ack, dram_dval, i_dram_id, i_dram_data,
               free_dval, i_free_id,
        input  alloc_ack, req_rdy, o_req_id, o_req_hiaddr, wad_dval, o_wid,
               o_whiaddr, o_wdata
    );

endinterface

// File: rtl/remap_cache_fill_ctrl_ring_ptr.sv
// Ring pointer over one config region: steps base..base+size-1 and wraps to
// base; reloads on reset or config load.
module remap_ring_ptr
    import remap_cache_fill_ctrl_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_load,
    input  hiaddr_t i_load_val,
    input  hiaddr_t i_base,
    input  occ_t    i_size,
    input  logic    i_adv,
    output hiaddr_t o_ptr
);

    hiaddr_t ptr_q, ptr_d;
    occ_t    last;

    // Last line computed one bit wider so base+size may exceed the HBW range.
    always_comb begin
        last  = {1'b0, i_base} + i_size - occ_t'(1);
        ptr_d = ptr_q;
        if (i_load) begin
            ptr_d = i_load_val;
        end else if (i_adv) begin
            ptr_d = ({1'b0, ptr_q} == last) ? i_base : ptr_q + hiaddr_t'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) ptr_q <= i_load_val;
        else       ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/remap_cache_fill_ctrl.sv
// RemapCache fill controller: reserves lines per config in circular regions,
// turns in-order DRAM beats into cache writes and releases lines on free.
module remap_cache_fill_ctrl
    import remap_cache_fill_ctrl_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_cfg_dval,
    input  logic [N_ICFG-1:0][HBW-1:0]     i_cfg_base,
    input  logic [N_ICFG-1:0][HBW:0]       i_cfg_size,
    remap_cache_fill_ctrl_if.slave         bus,
    output logic                           o_idle,
    output logic                           o_err
);

    logic [N_ICFG-1:0][HBW-1:0] base_q, base_d;
    logic [N_ICFG-1:0][HBW:0]   size_q, size_d;
    logic [N_ICFG-1:0][HBW:0]   occ_q, occ_d;
    logic [N_ICFG-1:0][HBW-1:0] alloc_ptr, fill_ptr, free_ptr;
    logic [N_ICFG-1:0]          alloc_adv, fill_adv, free_adv;

    logic     req_rdy_q, req_rdy_d;
    icfg_id_t req_id_q, req_id_d;
    hiaddr_t  req_hiaddr_q, req_hiaddr_d;
    logic     wad_q, wad_d;
    icfg_id_t wid_q, wid_d;
    hiaddr_t  whiaddr_q, whiaddr_d;
    line_t    wdata_q, wdata_d;
    logic     idle_q, idle_d;
    logic     err_q, err_d;

    logic     clr, alloc_ack, wr_ok, beat_err, free_ok, free_err;
    icfg_id_t aid, did, fid;

    assign clr = i_rst | i_cfg_dval;
    assign aid = bus.i_alloc_id;
    assign did = bus.i_dram_id;
    assign fid = bus.i_free_id;

    for (genvar g = 0; g < N_ICFG; g++) begin : g_ptr
        remap_ring_ptr u_alloc (
            .i_clk(i_clk), .i_rst(i_rst), .i_load(i_cfg_dval), .i_load_val(i_cfg_base[g]),
            .i_base(base_q[g]), .i_size(size_q[g]), .i_adv(alloc_adv[g]), .o_ptr(alloc_ptr[g])
        );
        remap_ring_ptr u_fill (
            .i_clk(i_clk), .i_rst(i_rst), .i_load(i_cfg_dval), .i_load_val(i_cfg_base[g]),
            .i_base(base_q[g]), .i_size(size_q[g]), .i_adv(fill_adv[g]), .o_ptr(fill_ptr[g])
        );
        remap_ring_ptr u_free (
            .i_clk(i_clk), .i_rst(i_rst), .i_load(i_cfg_dval), .i_load_val(i_cfg_base[g]),
            .i_base(base_q[g]), .i_size(size_q[g]), .i_adv(free_adv[g]), .o_ptr(free_ptr[g])
        );
    end

    // Event decode; acceptance uses registered occupancy so a full region
    // freed this cycle becomes allocatable only next cycle.
    always_comb begin
        alloc_ack = 1'b0;
        wr_ok     = 1'b0;
        beat_err  = 1'b0;
        free_ok   = 1'b0;
        free_err  = 1'b0;
        if (!clr) begin
            alloc_ack = bus.alloc_rdy && id_valid(aid) && (occ_q[aid] < size_q[aid]) &&
                        (!req_rdy_q || bus.req_ack);
            if (bus.dram_dval) begin
                if (!id_valid(did) || (fill_ptr[did] == alloc_ptr[did] && occ_q[did] == '0))
                    beat_err = 1'b1;
                else
                    wr_ok = 1'b1;
            end
            if (bus.free_dval) begin
                if (!id_valid(fid) || occ_q[fid] == '0) free_err = 1'b1;
                else                                    free_ok  = 1'b1;
            end
        end
        for (int i = 0; i < N_ICFG; i++) begin
            alloc_adv[i] = alloc_ack && (aid == icfg_id_t'(i));
            fill_adv[i]  = wr_ok     && (did == icfg_id_t'(i));
            free_adv[i]  = free_ok   && (fid == icfg_id_t'(i));
        end
    end

    always_comb begin
        base_d       = base_q;
        size_d       = size_q;
        occ_d        = occ_q;
        req_rdy_d    = req_rdy_q;
        req_id_d     = req_id_q;
        req_hiaddr_d = req_hiaddr_q;
        wad_d        = 1'b0;
        wid_d        = wid_q;
        whiaddr_d    = whiaddr_q;
        wdata_d      = wdata_q;
        err_d        = err_q | beat_err | free_err | (i_cfg_dval & ~idle_q);
        if (clr) begin
            base_d       = i_cfg_base;
            size_d       = i_cfg_size;
            occ_d        = '0;
            req_rdy_d    = 1'b0;
            req_id_d     = '0;
            req_hiaddr_d = '0;
            wid_d        = '0;
            whiaddr_d    = '0;
            wdata_d      = '0;
        end else begin
            if (alloc_ack) begin
                req_rdy_d    = 1'b1;
                req_id_d     = aid;
                req_hiaddr_d = alloc_ptr[aid];
            end else if (bus.req_ack) begin
                req_rdy_d = 1'b0;
            end
            if (wr_ok) begin
                wad_d     = 1'b1;
                wid_d     = did;
                whiaddr_d = fill_ptr[did];
                wdata_d   = bus.i_dram_data;
            end
            for (int i = 0; i < N_ICFG; i++)
                occ_d[i] = occ_q[i] + occ_t'(alloc_adv[i]) - occ_t'(free_adv[i]);
        end
        idle_d = clr | ((occ_d == '0) & ~req_rdy_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_q       <= i_cfg_base;
            size_q       <= i_cfg_size;
            occ_q        <= '0;
            req_rdy_q    <= 1'b0;
            req_id_q     <= '0;
            req_hiaddr_q <= '0;
            wad_q        <= 1'b0;
            wid_q        <= '0;
            whiaddr_q    <= '0;
            wdata_q      <= '0;
            idle_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            base_q       <= base_d;
            size_q       <= size_d;
            occ_q        <= occ_d;
            req_rdy_q    <= req_rdy_d;
            req_id_q     <= req_id_d;
            req_hiaddr_q <= req_hiaddr_d;
            wad_q        <= wad_d;
            wid_q        <= wid_d;
            whiaddr_q    <= whiaddr_d;
            wdata_q      <= wdata_d;
            idle_q       <= idle_d;
            err_q        <= err_d;
        end
    end

    assign bus.alloc_ack    = alloc_ack;
    assign bus.req_rdy      = req_rdy_q;
    assign bus.o_req_id     = req_id_q;
    assign bus.o_req_hiaddr = req_hiaddr_q;
    assign bus.wad_dval     = wad_q;
    assign bus.o_wid        = wid_q;
    assign bus.o_whiaddr    = whiaddr_q;
    assign bus.o_wdata      = wdata_q;
    assign o_idle           = idle_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_remap_cache_fill_ctrl.sv
// Directed bench for remap_cache_fill_ctrl: regions id0 base 4 size 3,
// id1 base 8 size 2, id2 base 12 size 4.
module tb_remap_cache_fill_ctrl;
    import remap_cache_fill_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, cfg_dval, idle, err;
    logic [N_ICFG-1:0][HBW-1:0] cfg_base;
    logic [N_ICFG-1:0][HBW:0]   cfg_size;
    line_t                      beats [3];
    int                         errors = 0;
    int                         checks = 0;

    remap_cache_fill_ctrl_if bus();

    remap_cache_fill_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_dval(cfg_dval), .i_cfg_base(cfg_base),
        .i_cfg_size(cfg_size), .bus(bus), .o_idle(idle), .o_err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL rst_req_rdy got=%b exp=0", bus.req_rdy); end
        checks++; if (bus.wad_dval !== 1'b0) begin errors++; $display("FAIL rst_wad got=%b exp=0", bus.wad_dval); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (bus.o_req_hiaddr !== 4'd0) begin errors++; $display("FAIL rst_hiaddr got=%0d exp=0", bus.o_req_hiaddr); end
        cfg_dval = 1'b1; tick(); cfg_dval = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfg_idle_err got=%b exp=0", err); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL cfg_idle got=%b exp=1", idle); end
    endtask

    task automatic test_alloc_wrap;
        bus.req_ack = 1'b1; bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd0; #1;
        checks++; if (bus.alloc_ack !== 1'b1) begin errors++; $display("FAIL wrap_ack0 got=%b exp=1", bus.alloc_ack); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL wrap_rdy%0d got=%b exp=1", k, bus.req_rdy); end
            checks++; if (bus.o_req_hiaddr !== hiaddr_t'(4 + k)) begin errors++; $display("FAIL wrap_hiaddr%0d got=%0d exp=%0d", k, bus.o_req_hiaddr, 4 + k); end
        end
        #1;
        checks++; if (bus.alloc_ack !== 1'b0) begin errors++; $display("FAIL full_ack got=%b exp=0", bus.alloc_ack); end
        tick();
        checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL drain_rdy got=%b exp=0", bus.req_rdy); end
        bus.free_dval = 1'b1; bus.i_free_id = 2'd0; #1;
        checks++; if (bus.alloc_ack !== 1'b0) begin errors++; $display("FAIL free_same_cycle_ack got=%b exp=0", bus.alloc_ack); end
        tick(); bus.free_dval = 1'b0; #1;
        checks++; if (bus.alloc_ack !== 1'b1) begin errors++; $display("FAIL after_free_ack got=%b exp=1", bus.alloc_ack); end
        tick();
        checks++; if (bus.o_req_hiaddr !== 4'd4) begin errors++; $display("FAIL wrap_hiaddr got=%0d exp=4", bus.o_req_hiaddr); end
        bus.alloc_rdy = 1'b0; tick();
        checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL wrap_end_rdy got=%b exp=0", bus.req_rdy); end
    endtask

    task automatic test_dram_fill;
        for (int k = 0; k < 3; k++) begin
            bus.dram_dval = 1'b1; bus.i_dram_id = 2'd0; bus.i_dram_data = beats[k];
            tick();
            checks++; if (bus.wad_dval !== 1'b1) begin errors++; $display("FAIL fill_wad%0d got=%b exp=1", k, bus.wad_dval); end
            checks++; if (bus.o_whiaddr !== hiaddr_t'(4 + k)) begin errors++; $display("FAIL fill_addr%0d got=%0d exp=%0d", k, bus.o_whiaddr, 4 + k); end
            checks++; if (bus.o_wdata !== beats[k]) begin errors++; $display("FAIL fill_data%0d got=%h exp=%h", k, bus.o_wdata, beats[k]); end
            checks++; if (bus.o_wid !== 2'd0) begin errors++; $display("FAIL fill_wid%0d got=%0d exp=0", k, bus.o_wid); end
        end
        bus.dram_dval = 1'b0; tick();
        checks++; if (bus.wad_dval !== 1'b0) begin errors++; $display("FAIL fill_end_wad got=%b exp=0", bus.wad_dval); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err got=%b exp=0", err); end
    endtask

    task automatic test_full_other_id;
        bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd0; #1;
        checks++; if (bus.alloc_ack !== 1'b0) begin errors++; $display("FAIL id0_full_ack got=%b exp=0", bus.alloc_ack); end
        tick();
        bus.i_alloc_id = 2'd1; bus.free_dval = 1'b1; bus.i_free_id = 2'd0; #1;
        checks++; if (bus.alloc_ack !== 1'b1) begin errors++; $display("FAIL id1_ack got=%b exp=1", bus.alloc_ack); end
        tick(); bus.free_dval = 1'b0;
        checks++; if (bus.o_req_id !== 2'd1) begin errors++; $display("FAIL id1_req_id got=%0d exp=1", bus.o_req_id); end
        checks++; if (bus.o_req_hiaddr !== 4'd8) begin errors++; $display("FAIL id1_hiaddr got=%0d exp=8", bus.o_req_hiaddr); end
        bus.i_alloc_id = 2'd0; #1;
        checks++; if (bus.alloc_ack !== 1'b1) begin errors++; $display("FAIL id0_freed_ack got=%b exp=1", bus.alloc_ack); end
        tick();
        checks++; if (bus.o_req_hiaddr !== 4'd5) begin errors++; $display("FAIL id0_next_hiaddr got=%0d exp=5", bus.o_req_hiaddr); end
        bus.alloc_rdy = 1'b0; tick();
    endtask

    task automatic test_free_underflow;
        bus.free_dval = 1'b1; bus.i_free_id = 2'd2; tick(); bus.free_dval = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL underflow_err got=%b exp=1", err); end
    endtask

    task automatic test_back_to_back;
        bus.req_ack = 1'b0; bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd1; #1;
        checks++; if (bus.alloc_ack !== 1'b1) begin errors++; $display("FAIL bp_first_ack got=%b exp=1", bus.alloc_ack); end
        tick(); bus.i_alloc_id = 2'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy%0d got=%b exp=1", i, bus.req_rdy); end
            checks++; if (bus.o_req_hiaddr !== 4'd9) begin errors++; $display("FAIL bp_hiaddr%0d got=%0d exp=9", i, bus.o_req_hiaddr); end
            checks++; if (bus.o_req_id !== 2'd1) begin errors++; $display("FAIL bp_id%0d got=%0d exp=1", i, bus.o_req_id); end
            checks++; if (bus.alloc_ack !== 1'b0) begin errors++; $display("FAIL bp_ack%0d got=%b exp=0", i, bus.alloc_ack); end
        end
        bus.req_ack = 1'b1; #1;
        checks++; if (bus.alloc_ack !== 1'b1) begin errors++; $display("FAIL bp_release_ack got=%b exp=1", bus.alloc_ack); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.o_req_hiaddr !== hiaddr_t'(12 + k)) begin errors++; $display("FAIL b2b_hiaddr%0d got=%0d exp=%0d", k, bus.o_req_hiaddr, 12 + k); end
            checks++; if (bus.o_req_id !== 2'd2) begin errors++; $display("FAIL b2b_id%0d got=%0d exp=2", k, bus.o_req_id); end
        end
        bus.alloc_rdy = 1'b0; tick();
        checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_end_rdy got=%b exp=0", bus.req_rdy); end
    endtask

    task automatic test_reset_midstream;
        bus.req_ack = 1'b0; bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd2; tick(); bus.alloc_rdy = 1'b0;
        checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy got=%b exp=1", bus.req_rdy); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b exp=0", idle); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got=%b exp=0", bus.req_rdy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle got=%b exp=1", idle); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", err); end
        bus.req_ack = 1'b1; bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd2; tick(); bus.alloc_rdy = 1'b0;
        checks++; if (bus.o_req_hiaddr !== 4'd12) begin errors++; $display("FAIL midrst_base got=%0d exp=12", bus.o_req_hiaddr); end
        tick();
        bus.dram_dval = 1'b1; bus.i_dram_id = 2'd1; bus.i_dram_data = beats[0]; tick(); bus.dram_dval = 1'b0;
        checks++; if (bus.wad_dval !== 1'b0) begin errors++; $display("FAIL orphan_wad got=%b exp=0", bus.wad_dval); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_err got=%b exp=1", err); end
    endtask

    task automatic test_cfg_err;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfgerr_pre got=%b exp=0", err); end
        bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd0; tick(); bus.alloc_rdy = 1'b0; tick();
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL cfgerr_busy got=%b exp=0", idle); end
        cfg_dval = 1'b1; tick(); cfg_dval = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL cfgerr_err got=%b exp=1", err); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL cfgerr_idle got=%b exp=1", idle); end
        bus.alloc_rdy = 1'b1; bus.i_alloc_id = 2'd0; tick(); bus.alloc_rdy = 1'b0;
        checks++; if (bus.o_req_hiaddr !== 4'd4) begin errors++; $display("FAIL cfgerr_base got=%0d exp=4", bus.o_req_hiaddr); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_dval = 1'b0;
        cfg_base[0] = 4'd4;  cfg_size[0] = 5'd3;
        cfg_base[1] = 4'd8;  cfg_size[1] = 5'd2;
        cfg_base[2] = 4'd12; cfg_size[2] = 5'd4;
        beats[0] = 32'h0102_0304; beats[1] = 32'hA5A5_5A5A; beats[2] = 32'hDEAD_BEEF;
        bus.alloc_rdy = 1'b0; bus.i_alloc_id = '0; bus.req_ack = 1'b0;
        bus.dram_dval = 1'b0; bus.i_dram_id = '0; bus.i_dram_data = '0;
        bus.free_dval = 1'b0; bus.i_free_id = '0;
        test_reset();
        test_alloc_wrap();
        test_dram_fill();
        test_full_other_id();
        test_free_underflow();
        test_back_to_back();
        test_reset_midstream();
        test_cfg_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/remap_cache_fill_ctrl.md
Name: remap_cache_fill_ctrl

Overview:
- Upstream allocation/fill controller for the RemapCache write port: reserves cache lines per input config (ICFG) in a circular region, emits the reserved line address toward the DRAM request path, and converts in-order DRAM return beats into RemapCache writes (wad_dval, i_wid, i_whiaddr, i_wdata).
- Consumes the RemapCache free event (free_dval, o_free_id) to release lines, closing the credit loop.
- Lines are VSIZE-wide words at hiaddr granularity.

Parameters:
- LBW, TauCfg::LOCAL_ADDR_BW0, local address width; HBW = LBW-$clog2(VSIZE), NDATA = 1<<HBW.
- N_ICFG, TauCfg::N_ICFG, number of input configs; ICFG_BW = $clog2(N_ICFG+1).
- VSIZE, TauCfg::VSIZE, banks (words per line).
- DBW, TauCfg::DATA_BW, word width.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_cfg_dval  in  1  load region config and clear all state.
- i_cfg_base  in  HBW x N_ICFG  first line of each region.
- i_cfg_size  in  (HBW+1) x N_ICFG  lines per region; 1..NDATA.
- alloc_rdy  in  1  allocation request valid.
- alloc_ack  out  1  request accepted this cycle.
- i_alloc_id  in  ICFG_BW  config of request.
- req_rdy  out  1  reserved-line output valid.
- req_ack  in  1  downstream accepts reserved line.
- o_req_id  out  ICFG_BW  config of reserved line.
- o_req_hiaddr  out  HBW  reserved line address.
- dram_dval  in  1  DRAM return beat valid (one line).
- i_dram_id  in  ICFG_BW  config of beat.
- i_dram_data  in  DBW x VSIZE  line data.
- wad_dval  out  1  RemapCache write strobe.
- o_wid  out  ICFG_BW  write config id.
- o_whiaddr  out  HBW  write line address.
- o_wdata  out  DBW x VSIZE  write data.
- free_dval  in  1  line release from RemapCache.
- i_free_id  in  ICFG_BW  config of released line.
- o_idle  out  1  all occupancies zero, no pending req.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Per-config state: alloc_ptr, fill_ptr, free_ptr (HBW), occ (HBW+1). Pointers advance base..base+size-1, then wrap to base (compare against base+size-1, not power-of-2 wrap; sum computed at HBW+1 bits).
- Reset or i_cfg_dval: all pointers = base, occ = 0, req_rdy = 0, wad_dval = 0, o_wid/o_whiaddr/o_wdata/o_req_* = 0, o_idle = 1, o_err = 0 (cfg does not clear o_err; reset does). Reset dominates cfg.
- Alloc: alloc_ack = alloc_rdy && occ[id] < size[id] && (!req_rdy || req_ack) && !i_cfg_dval. On ack: next cycle req_rdy = 1, o_req_id = id, o_req_hiaddr = old alloc_ptr[id]; alloc_ptr advances; occ++. Same-cycle req_ack and new ack gives back-to-back output (throughput 1/cycle). req_rdy held with stable data until req_ack.
- Full: occ == size stalls that id only (alloc_ack = 0); other ids unaffected.
- DRAM return: 1-cycle latency; wad_dval = dram_dval registered, o_whiaddr = fill_ptr[id], o_wdata/o_wid registered copies; fill_ptr advances. Beats within one id arrive in allocation order. Beat with fill_ptr == alloc_ptr and occ == 0 (no reservation) -> o_err set, no write.
- Free: free_dval advances free_ptr[id], occ--. Free with occ == 0 -> o_err set, ignored.
- Simultaneous alloc ack and free on same id: occ unchanged, both pointers advance; this makes a full region allocatable only the next cycle (ack uses registered occ).
- i_cfg_dval while !o_idle -> o_err set; state still cleared.
- o_idle registered: all occ == 0 and !req_rdy.

Decomposition:
- TauCfg package: LOCAL_ADDR_BW0, N_ICFG, VSIZE, DATA_BW (existing). Add RemapFillErr constants only if the error flag is later split.
- One sub-module: remap_ring_ptr (per-config ring pointer with base/size wrap, instantiated 3 x N_ICFG).

Test Plan:
- Cfg id0 base=4 size=3; 4 allocs on id0 -> o_req_hiaddr 4,5,6, 4th alloc_ack = 0 until one free_dval id0, then hiaddr 4 (wrap).
- 3 DRAM beats id0 data k -> wad_dval each next cycle, o_whiaddr 4,5,6, o_wdata equals input.
- req_ack held 0 for 5 cycles -> req_rdy/o_req_* stable, alloc_ack = 0; release -> one transfer per cycle.
- id0 full plus same-cycle free and alloc on id1 -> id1 acked, id0 occ 3->2.
- free_dval id2 with occ 0 -> o_err = 1, occ stays 0.
- i_rst mid-stream (req_rdy = 1, occ = 2) -> next cycle req_rdy = 0, o_idle = 1, next alloc gets base.
